// File: rtl/md5core_sched.sv
// Input scheduler for a two-context, two-sequence MD5 core: a free-running round timer plus a
// round-robin writer that streams one 16-word block at a time from either requester into a free core slot.
`ifndef BLK_OP_MSB
`define BLK_OP_MSB 3
`endif

module md5core_sched #(
  parameter int PERIOD   = 144,
  parameter int BLK_OP_W = `BLK_OP_MSB + 1
) (
  input  logic                CLK,
  input  logic                rst,
  input  logic [1:0]          rq_valid,
  input  logic [31:0]         rq_data0,
  input  logic [31:0]         rq_data1,
  input  logic [BLK_OP_W-1:0] rq_blk_op0,
  input  logic [BLK_OP_W-1:0] rq_blk_op1,
  output logic [1:0]          rq_ready,
  input  logic [3:0]          core_ready,
  output logic                wr_en,
  output logic [31:0]         din,
  output logic [3:0]          wr_addr,
  output logic [BLK_OP_W-1:0] input_blk_op,
  output logic                input_ctx,
  output logic                input_seq,
  output logic                set_input_ready,
  output logic                start,
  output logic                ctx_num,
  output logic                seq_num,
  output logic                blk_done,
  output logic                blk_req,
  output logic                blk_ctx,
  output logic                blk_seq
);
  localparam int TW = $clog2(PERIOD);

  typedef enum logic {IDLE, WRITE} state_t;
  state_t state_reg, state_next;

  logic [TW-1:0]       tcnt_reg;
  logic                seq_reg;
  logic                g_reg, last_reg;
  logic [1:0]          slot_reg;
  logic [3:0]          wcnt_reg;
  logic                wr_en_reg, sir_reg;
  logic [31:0]         din_reg;
  logic [3:0]          addr_reg;
  logic [BLK_OP_W-1:0] op_reg;
  logic                blk_req_reg, blk_ctx_reg, blk_seq_reg;

  logic [3:0] avail;
  logic [1:0] grant_slot;
  logic       grant_g, want, accept, last_word;

  // Round timer: free-running, untouched by the write path.
  always_ff @(posedge CLK) begin
    if (rst) begin
      tcnt_reg <= '0;
      seq_reg  <= 1'b0;
    end else if (tcnt_reg == TW'(PERIOD - 1)) begin
      tcnt_reg <= '0;
      seq_reg  <= ~seq_reg;
    end else begin
      tcnt_reg <= tcnt_reg + TW'(1);
    end
  end

  assign start   = (tcnt_reg < TW'(2));
  assign ctx_num = tcnt_reg[0];
  assign seq_num = seq_reg;

  // The slot just completed is still flagged free by the core while set_input_ready is out.
  always_comb begin
    avail = core_ready;
    if (sir_reg) avail[{blk_ctx_reg, blk_seq_reg}] = 1'b0;
    grant_slot = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (avail[i]) grant_slot = 2'(i);
    end
    if (rq_valid == 2'b11) grant_g = ~last_reg;
    else                   grant_g = ~rq_valid[0];
  end

  assign want      = (rq_valid != 2'b00) && (avail != 4'b0000);
  assign accept    = (state_reg == WRITE) && rq_valid[g_reg];
  assign last_word = accept && (wcnt_reg == 4'd15);

  always_ff @(posedge CLK) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (want) state_next = WRITE;
      WRITE:   if (last_word) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rq_ready = 2'b00;
    if (state_reg == WRITE) rq_ready[g_reg] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      g_reg       <= 1'b0;
      last_reg    <= 1'b1;
      slot_reg    <= 2'd0;
      wcnt_reg    <= 4'd0;
      wr_en_reg   <= 1'b0;
      sir_reg     <= 1'b0;
      din_reg     <= 32'd0;
      addr_reg    <= 4'd0;
      op_reg      <= '0;
      blk_req_reg <= 1'b0;
      blk_ctx_reg <= 1'b0;
      blk_seq_reg <= 1'b0;
    end else begin
      wr_en_reg <= accept;
      sir_reg   <= last_word;
      if ((state_reg == IDLE) && want) begin
        g_reg    <= grant_g;
        slot_reg <= grant_slot;
        wcnt_reg <= 4'd0;
      end
      if (accept) begin
        din_reg  <= g_reg ? rq_data1 : rq_data0;
        addr_reg <= wcnt_reg;
        wcnt_reg <= wcnt_reg + 4'd1;
      end
      if (last_word) begin
        op_reg      <= g_reg ? rq_blk_op1 : rq_blk_op0;
        blk_req_reg <= g_reg;
        blk_ctx_reg <= slot_reg[1];
        blk_seq_reg <= slot_reg[0];
        last_reg    <= g_reg;
      end
    end
  end

  assign wr_en           = wr_en_reg;
  assign din             = din_reg;
  assign wr_addr         = addr_reg;
  assign input_blk_op    = op_reg;
  assign input_ctx       = slot_reg[1];
  assign input_seq       = slot_reg[0];
  assign set_input_ready = sir_reg;
  assign blk_done        = sir_reg;
  assign blk_req         = blk_req_reg;
  assign blk_ctx         = blk_ctx_reg;
  assign blk_seq         = blk_seq_reg;
endmodule

// File: tb/tb_md5core_sched.sv
// Bench for md5core_sched: a block-level model of timer, grant and write stream checked every cycle,
// a small core model that clears a slot's free flag on set_input_ready, and directed block scenarios.
module tb_md5core_sched;
  localparam int P = 144;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [31:0] d0 = '0, d1 = '0;
  logic [3:0]  op0 = '0, op1 = '0;
  logic [3:0]  core_ready = 4'b0000;
  wire  [1:0]  rq_valid = {v1, v0};
  logic [1:0]  rq_ready;
  logic        wr_en, input_ctx, input_seq, set_input_ready, start, ctx_num, seq_num;
  logic        blk_done, blk_req, blk_ctx, blk_seq;
  logic [31:0] din;
  logic [3:0]  wr_addr, input_blk_op;

  md5core_sched #(.PERIOD(P), .BLK_OP_W(4)) dut (
    .CLK(CLK), .rst(rst), .rq_valid(rq_valid), .rq_data0(d0), .rq_data1(d1),
    .rq_blk_op0(op0), .rq_blk_op1(op1), .rq_ready(rq_ready), .core_ready(core_ready),
    .wr_en(wr_en), .din(din), .wr_addr(wr_addr), .input_blk_op(input_blk_op),
    .input_ctx(input_ctx), .input_seq(input_seq), .set_input_ready(set_input_ready),
    .start(start), .ctx_num(ctx_num), .seq_num(seq_num), .blk_done(blk_done),
    .blk_req(blk_req), .blk_ctx(blk_ctx), .blk_seq(blk_seq)
  );

  always #5 CLK = ~CLK;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask

  function automatic int lowest(input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[i]) return i;
    return 0;
  endfunction

  // Model state
  int   cyc = 0;
  bit   armed = 0, rst_prev = 0;
  bit   exp_wr = 0, exp_final = 0;
  logic [31:0] exp_din;
  logic [3:0]  exp_addr, exp_op;
  int   exp_req, exp_slot;
  bit   active = 0, pend = 0;
  int   cur_g, cur_slot, words, last_served = 1, pend_g, pend_slot;
  // Statistics for literal pins
  int   wr_cnt = 0, sir_cnt = 0, start_cnt = 0, first_wr = 0, span = 0;
  logic seq_at_p = 1'b0;
  logic [31:0] last_din = '0;
  int   hist_req[$], hist_slot[$];
  // Core model
  bit   clr_req = 0;
  logic [3:0] clr_mask = '0;

  always @(posedge CLK) begin
    if (clr_req) begin
      #1;
      core_ready = core_ready & ~clr_mask;
      clr_req = 0;
    end
  end

  always @(negedge CLK) begin : compare
    logic [3:0] avail;
    bit nw, nf;
    if (rst_prev) begin
      cyc = 0; armed = 1; active = 0; pend = 0; exp_wr = 0; exp_final = 0;
      last_served = 1; words = 0;
    end
    if (armed) begin
      chk("start", start, ((cyc % P) < 2) ? 1 : 0);
      chk("ctx_num", ctx_num, cyc % 2);
      chk("seq_num", seq_num, (cyc / P) % 2);
      if (rst_prev) begin
        chk("rst_din", din, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_input_ctx", input_ctx, 0);
        chk("rst_input_seq", input_seq, 0);
        chk("rst_input_blk_op", input_blk_op, 0);
      end
      chk("wr_en", wr_en, exp_wr);
      chk("set_input_ready", set_input_ready, (exp_wr && exp_final) ? 1 : 0);
      chk("blk_done", blk_done, (exp_wr && exp_final) ? 1 : 0);
      if (exp_wr) begin
        chk("din", din, exp_din);
        chk("wr_addr", wr_addr, exp_addr);
        chk("input_ctx", input_ctx, exp_slot / 2);
        chk("input_seq", input_seq, exp_slot % 2);
        if (exp_final) begin
          chk("blk_req", blk_req, exp_req);
          chk("blk_ctx", blk_ctx, exp_slot / 2);
          chk("blk_seq", blk_seq, exp_slot % 2);
          chk("input_blk_op", input_blk_op, exp_op);
        end
      end
      if (pend) begin
        chk("rq_ready_grant", rq_ready, 1 << pend_g);
        active = 1; cur_g = pend_g; cur_slot = pend_slot; words = 0; pend = 0;
      end else if (active) begin
        chk("rq_ready_write", rq_ready, 1 << cur_g);
      end else begin
        chk("rq_ready_idle", rq_ready, 0);
      end

      avail = core_ready;
      if (exp_wr && exp_final) avail = avail & ~(4'(1) << exp_slot);
      nw = 0; nf = 0;
      if (!rst) begin
        if (active) begin
          if (rq_valid[cur_g]) begin
            nw = 1;
            nf = (words == 15);
            exp_din  = cur_g ? d1 : d0;
            exp_op   = cur_g ? op1 : op0;
            exp_addr = 4'(words);
            exp_req  = cur_g;
            exp_slot = cur_slot;
            words++;
            if (nf) begin
              active = 0;
              last_served = cur_g;
            end
          end
        end else if (rq_valid != 2'b00 && avail != 4'b0000) begin
          pend = 1;
          pend_g = (rq_valid == 2'b11) ? 1 - last_served : (rq_valid[0] ? 0 : 1);
          pend_slot = lowest(avail);
        end
      end
      exp_wr = nw; exp_final = nf;

      if (wr_en) begin
        wr_cnt++;
        if (wr_addr == 4'd0) first_wr = cyc;
      end
      if (set_input_ready) begin
        sir_cnt++;
        hist_req.push_back(int'(blk_req));
        hist_slot.push_back(int'({blk_ctx, blk_seq}));
        last_din = din;
        span = cyc - first_wr;
        clr_req = 1;
        clr_mask = 4'(1) << {blk_ctx, blk_seq};
        $display("block req=%0d ctx=%0d seq=%0d op=%h last_din=%h cyc=%0d",
                 blk_req, blk_ctx, blk_seq, input_blk_op, din, cyc);
      end
      if (!rst && start && cyc < 2 * P) start_cnt++;
      if (cyc == P) seq_at_p = seq_num;
    end
    cyc++;
    rst_prev = rst;
  end

  task automatic set_req(input int r, input logic v, input logic [31:0] d, input logic [3:0] op);
    if (r == 0) begin v0 = v; d0 = d; op0 = op; end
    else        begin v1 = v; d1 = d; op1 = op; end
  endtask

  // Streams one block; the block op is only meaningful on word 15 (junk elsewhere).
  task automatic drive(input int r, input logic [31:0] base, input logic [3:0] op,
                       input int bub_a, input int bub_b, input int stop_at);
    int k = 0, guard = 0;
    bit bubbled = 0;
    while (k < 16 && guard < 3000) begin
      if ((k == bub_a || k == bub_b) && !bubbled) begin
        set_req(r, 1'b0, base + 32'(k), ~op);
        bubbled = 1;
      end else begin
        set_req(r, 1'b1, base + 32'(k), (k == 15) ? op : ~op);
      end
      @(negedge CLK);
      if (rq_valid[r] && rq_ready[r]) begin
        if (k == stop_at) return;
        k++;
        bubbled = 0;
      end
      @(posedge CLK); #1;
      guard++;
    end
    if (guard >= 3000) begin
      errors++;
      $display("FAIL drive_timeout req=%0d got=%0d words want=16", r, k);
    end
    set_req(r, 1'b0, 32'd0, 4'd0);
  endtask

  task automatic do_reset(input logic [3:0] cr);
    @(posedge CLK); #1;
    rst = 1; v0 = 0; v1 = 0;
    repeat (2) begin @(posedge CLK); #1; end
    core_ready = cr;
    rst = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  initial begin
    int s, guard;
    // Timer
    repeat (3) begin @(posedge CLK); #1; end
    rst = 0;
    idle(2 * P + 4);
    chk("pin_start_count", start_cnt, 4);
    chk("pin_seq_at_period", seq_at_p, 1);

    // Single block from requester 0
    core_ready = 4'b1111;
    drive(0, 32'h100, 4'h5, -1, -1, -1);
    idle(4);
    chk("pin_single_sir", sir_cnt, 1);
    chk("pin_single_wr", wr_cnt, 16);
    chk("pin_single_last_din", last_din, 32'h10F);
    chk("pin_single_req", hist_req[0], 0);
    chk("pin_single_slot", hist_slot[0], 0);

    // Contention after reset: requester 0 wins the tie, requester 1 goes to slot 1
    do_reset(4'b1111);
    fork
      drive(0, 32'h200, 4'h3, -1, -1, -1);
      drive(1, 32'h300, 4'hA, -1, -1, -1);
    join
    idle(4);
    chk("pin_cont_req0", hist_req[1], 0);
    chk("pin_cont_slot0", hist_slot[1], 0);
    chk("pin_cont_req1", hist_req[2], 1);
    chk("pin_cont_slot1", hist_slot[2], 1);
    chk("pin_cont_last_din", last_din, 32'h30F);

    // Bubbles on words 3 and 9
    s = wr_cnt;
    drive(0, 32'h400, 4'h9, 3, 9, -1);
    idle(4);
    chk("pin_bub_wr", wr_cnt - s, 16);
    chk("pin_bub_sir", sir_cnt, 4);
    chk("pin_bub_span", span, 17);
    chk("pin_bub_slot", hist_slot[3], 2);

    // Core full: nothing moves until slot 2 frees, then slot 3 for the loser
    do_reset(4'b0000);
    s = wr_cnt;
    fork
      drive(0, 32'h500, 4'h1, -1, -1, -1);
      drive(1, 32'h600, 4'h2, -1, -1, -1);
      begin
        idle(50);
        chk("pin_full_no_wr", wr_cnt - s, 0);
        core_ready = core_ready | 4'b0100;
        guard = 0;
        while (sir_cnt < 5 && guard < 500) begin @(negedge CLK); guard++; end
        chk("pin_full_first_done", sir_cnt, 5);
        @(posedge CLK); #1;
        core_ready = core_ready | 4'b1000;
      end
    join
    idle(4);
    chk("pin_full_req", hist_req[4], 0);
    chk("pin_full_slot", hist_slot[4], 2);
    chk("pin_full_req2", hist_req[5], 1);
    chk("pin_full_slot2", hist_slot[5], 3);

    // Reset on word 7 aborts the block
    do_reset(4'b1111);
    s = sir_cnt;
    drive(0, 32'h700, 4'h7, -1, -1, 7);
    @(posedge CLK); #1;
    rst = 1; v0 = 0;
    @(posedge CLK); #1;
    rst = 0;
    idle(30);
    chk("pin_abort_no_sir", sir_cnt - s, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
